serial_add_ctrl: RTL

Bit-serial add/subtract controller that sequences one 1-bit full-adder cell over WIDTH-bit operands, LSB first, one bit per clock. It captures operands on a start request, then drives the full-adder inputs from operand shift registers and feeds the carry back through a carry flop. It presents the WIDTH-bit result plus carry-out with a done pulse. It trades WIDTH cycles of latency for a single adder cell.

---
 rtl/serial_add_ctrl_pkg.sv | 17 +
 rtl/serial_add_ctrl_fa.sv | 22 ++
 rtl/serial_add_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// rtl/serial_add_ctrl_pkg.sv - shared encodings for the bit-serial add/subtract controller
//
// Purpose: FSM state and operation encodings shared by the controller and its bench.
// Ports:   none (package).

package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// rtl/serial_add_ctrl_fa.sv - 1-bit gate-level full-adder cell
//
// Purpose: single full-adder cell used as the whole datapath of the serial adder.
// Ports:
//   a, b, cin : addend bits and carry-in
//   s, cout   : sum bit and carry-out

module serial_add_ctrl_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic axb;

    assign axb  = a ^ b;
    assign s    = axb ^ cin;
    assign cout = (a & b) | (cin & axb);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract controller around one full-adder cell
//
// Purpose: captures WIDTH-bit operands on start, processes one bit per clock LSB
//          first through a single full-adder cell, then presents sum/cout with a
//          one-cycle done pulse.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   start      : request, honoured only in IDLE or DONE
//   op         : 0 = add (a + b + cin), 1 = subtract (a - b)
//   a, b, cin  : operands and carry-in (cin ignored for subtract)
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when sum/cout become valid
//   sum, cout  : result and final carry (subtract: 1 = no borrow)

module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   sh_a;
    logic [WIDTH-1:0]   sh_b;
    logic [WIDTH-1:0]   res;
    logic [WIDTH-1:0]   res_next;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_s;
    logic               fa_cout;
    logic               last_bit;
    logic               load;

    serial_add_ctrl_fa u_fa (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign load     = start && ((state == ST_IDLE) || (state == ST_DONE));

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    // Written as shift/or so it also holds for WIDTH == 1.
    assign res_next = (res >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_RUN;
            ST_RUN:  if (last_bit) next_state = ST_DONE;
            ST_DONE: next_state = start ? ST_RUN : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a  <= '0;
            sh_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            sh_a  <= a;
            // Subtract as a + ~b + 1: invert B and force the initial carry.
            sh_b  <= (op == OP_SUB) ? ~b : b;
            carry <= (op == OP_SUB) ? 1'b1 : cin;
            cnt   <= '0;
            res   <= '0;
        end else if (state == ST_RUN) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            res   <= res_next;
            carry <= fa_cout;
            cnt   <= cnt + CNT_W'(1);
            if (last_bit) begin
                sum  <= res_next;
                cout <= fa_cout;
            end
        end
    end

endmodule
